// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared UART types, parity modes and baud arithmetic  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    BREAK = 3'd5
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int pulse_width(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync2.sv
// ---------------------------------------------------------------------------
// uart_sync2 : two-flop synchroniser with configurable reset value  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 (optional parity) receiver with one-entry holding register (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int PARITY     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_sig,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun
);

  localparam int PULSE_WIDTH      = pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int CNT_W            = $clog2(PULSE_WIDTH + 1);
  localparam int BIT_W            = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic                  rx_s;
  rx_state_t             state;
  logic [CNT_W-1:0]      clk_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  par_bad;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_sig),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift_r    <= '0;
      par_bad    <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;

      // A delivery later in this block overrides the consume-clear.
      if (valid && ready) valid <= 1'b0;
      if (clk_cnt != '0) clk_cnt <= clk_cnt - 1'b1;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            clk_cnt <= CNT_W'(HALF_PULSE_WIDTH - 1);
            state   <= START;
          end
        end
        START: begin
          if (clk_cnt == '0) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              bit_cnt <= '0;
              par_bad <= 1'b0;
              clk_cnt <= CNT_W'(PULSE_WIDTH - 1);
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (clk_cnt == '0) begin
            // LSB first: after DATA_WIDTH right shifts bit 0 lands in shift_r[0].
            shift_r <= {rx_s, shift_r[DATA_WIDTH-1:1]};
            clk_cnt <= CNT_W'(PULSE_WIDTH - 1);
            if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
              state <= (PARITY != PAR_NONE) ? PAR : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PAR: begin
          if (clk_cnt == '0) begin
            par_bad <= (PARITY == PAR_ODD) ? ~(^shift_r ^ rx_s) : (^shift_r ^ rx_s);
            clk_cnt <= CNT_W'(PULSE_WIDTH - 1);
            state   <= STOP;
          end
        end
        STOP: begin
          if (clk_cnt == '0) begin
            if (rx_s) begin
              if (!valid || ready) begin
                data  <= shift_r;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              parity_err <= par_bad;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : directed self-checking bench for uart_rx  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

  localparam int CF = 1_600_000;
  localparam int BR = 100_000;
  localparam int PW = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx, rx_p;
  logic       ready, ready_p;
  logic [7:0] data, data_p;
  logic       valid, valid_p;
  logic       frame_err, parity_err, overrun;
  logic       frame_err_p, parity_err_p, overrun_p;

  uart_rx #(.DATA_WIDTH(8), .BAUD_RATE(BR), .CLK_FREQ(CF), .PARITY(0)) dut (
    .clk(clk), .rst(rst), .rx_sig(rx), .data(data), .valid(valid), .ready(ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  uart_rx #(.DATA_WIDTH(8), .BAUD_RATE(BR), .CLK_FREQ(CF), .PARITY(2)) dut_p (
    .clk(clk), .rst(rst), .rx_sig(rx_p), .data(data_p), .valid(valid_p), .ready(ready_p),
    .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation side: words transferred, pulse counts, valid-rise time.
  logic [7:0] rxw  [0:511];
  logic [7:0] rxw_p[0:15];
  int rx_n = 0, rx_n_p = 0;
  int n_ferr = 0, n_perr = 0, n_ovr = 0, n_vcyc = 0;
  int n_ferr_p = 0, n_perr_p = 0;
  int rise_cyc = 0;
  logic valid_q = 1'b0;

  always @(negedge clk) begin
    if (valid && ready) begin
      rxw[rx_n] = data;
      rx_n++;
    end
    if (valid_p && ready_p) begin
      rxw_p[rx_n_p] = data_p;
      rx_n_p++;
    end
    if (valid)        n_vcyc++;
    if (frame_err)    n_ferr++;
    if (parity_err)   n_perr++;
    if (overrun)      n_ovr++;
    if (frame_err_p)  n_ferr_p++;
    if (parity_err_p) n_perr_p++;
    if (valid && !valid_q) rise_cyc = cyc;
    valid_q = valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int fall_cyc = 0;

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic p);
    if (p) rx_p = b;
    else   rx   = b;
    idle(PW);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic pbit, input logic stopb);
    fall_cyc = cyc;
    send_bit(1'b0, p);
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (p) send_bit(pbit, p);
    send_bit(stopb, p);
  endtask

  int rd, vc, fe, pe, ov, lat;

  initial begin
    rst = 1'b1; rx = 1'b1; rx_p = 1'b1; ready = 1'b1; ready_p = 1'b1;
    idle(4);
    check("reset_data",  32'(data), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_errs",  32'({frame_err, parity_err, overrun}), 32'h0);
    check("reset_valid_p", 32'(valid_p), 32'h0);
    rst = 1'b0;
    idle(4);

    // Basic frame, latency and single-cycle valid
    rd = rx_n; vc = n_vcyc; fe = n_ferr; pe = n_perr; ov = n_ovr;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    idle(4);
    check("a5_count", 32'(rx_n - rd), 32'd1);
    check("a5_data",  32'(rxw[rd]), 32'hA5);
    check("a5_vcyc",  32'(n_vcyc - vc), 32'd1);
    check("a5_errs",  32'((n_ferr - fe) + (n_perr - pe) + (n_ovr - ov)), 32'd0);
    lat = rise_cyc - fall_cyc;
    if (lat >= 154 && lat <= 156) check("a5_latency", 32'(lat), 32'(lat));
    else check("a5_latency", 32'(lat), 32'd155);

    // Start-bit glitch
    rd = rx_n; fe = n_ferr; ov = n_ovr;
    rx = 1'b0; idle(4); rx = 1'b1; idle(48);
    check("glitch_words", 32'(rx_n - rd), 32'd0);
    check("glitch_valid", 32'(valid), 32'd0);
    check("glitch_ferr",  32'(n_ferr - fe), 32'd0);
    check("glitch_ovr",   32'(n_ovr - ov), 32'd0);

    // Framing error then held-low line, followed by a good frame
    rd = rx_n; fe = n_ferr;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'(8'h3C >> i), 1'b0);
    for (int i = 0; i < 40; i++) send_bit(1'b0, 1'b0);
    rx = 1'b1; idle(32);
    check("ferr_count", 32'(n_ferr - fe), 32'd1);
    check("ferr_words", 32'(rx_n - rd), 32'd0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    idle(4);
    check("after_ferr_count", 32'(rx_n - rd), 32'd1);
    check("after_ferr_data",  32'(rxw[rd]), 32'h55);
    check("after_ferr_ferr",  32'(n_ferr - fe), 32'd1);

    // Even parity: good then bad parity bit
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    idle(4);
    check("par_ok_count", 32'(rx_n_p), 32'd1);
    check("par_ok_data",  32'(rxw_p[0]), 32'h07);
    check("par_ok_perr",  32'(n_perr_p), 32'd0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    idle(4);
    check("par_bad_count", 32'(rx_n_p), 32'd2);
    check("par_bad_data",  32'(rxw_p[1]), 32'h07);
    check("par_bad_perr",  32'(n_perr_p), 32'd1);
    check("par_ferr",      32'(n_ferr_p), 32'd0);

    // Overrun with a stalled consumer
    rd = rx_n; ov = n_ovr;
    ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    idle(4);
    check("ovr_data",  32'(data), 32'h11);
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_count", 32'(n_ovr - ov), 32'd1);
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
    check("ovr_cleared", 32'(valid), 32'd0);
    check("ovr_xfer",    32'(rx_n - rd), 32'd1);
    check("ovr_xdata",   32'(rxw[rd]), 32'h11);
    ready = 1'b1;
    idle(4);

    // Reset in the middle of a data field
    rd = rx_n; fe = n_ferr;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    rst = 1'b1; rx = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(32);
    check("rst_words", 32'(rx_n - rd), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ferr",  32'(n_ferr - fe), 32'd0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    idle(4);
    check("rst_next_count", 32'(rx_n - rd), 32'd1);
    check("rst_next_data",  32'(rxw[rd]), 32'h81);

    // Back-to-back stream of all byte values
    rd = rx_n; fe = n_ferr; pe = n_perr; ov = n_ovr;
    for (int w = 0; w < 256; w++) send_frame(8'(w), 1'b0, 1'b0, 1'b1);
    idle(4);
    check("stream_count", 32'(rx_n - rd), 32'd256);
    for (int w = 0; w < 256; w++) check("stream_word", 32'(rxw[rd + w]), 32'(w));
    check("stream_errs", 32'((n_ferr - fe) + (n_perr - pe) + (n_ovr - ov)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver. It deserialises an asynchronous 8N1 line (optional parity) into parallel words and presents them on a valid/ready handshake. It is the receive-side counterpart of the team's uart_tx and uses the same baud arithmetic, so a tx→rx loopback interoperates. A one-entry output holding register absorbs consumer stalls, and framing, parity and overrun errors are flagged.

Parameters:
- DATA_WIDTH, 8: data bits per frame, LSB first.
- BAUD_RATE, 115200: line bit rate.
- CLK_FREQ, 100_000_000: clk frequency in Hz.
- PARITY, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- PULSE_WIDTH, localparam CLK_FREQ/BAUD_RATE: clocks per bit.
- HALF_PULSE_WIDTH, localparam PULSE_WIDTH/2: clocks to the mid-point of a bit.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_sig  in  1  asynchronous serial line, idle high.
- data  out  DATA_WIDTH  received word; stable while valid=1.
- valid  out  1  data holds an unconsumed word.
- ready  in  1  consumer accepts; a transfer occurs when valid & ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch (always 0 when PARITY=0).
- overrun  out  1  one-cycle pulse: a word completed while the holding register was full.

Behaviour:
- Synchroniser
  - rx_sig passes through a 2-flop synchroniser (reset value 1) before any use.
  - All timing below is relative to the synchronised signal, rx_s.
- Reset
  - rst=1 at a clk edge: state=IDLE, counters=0, data=0, valid=0, all error pulses 0, synchroniser flops=1.
  - Reset mid-frame abandons the frame with no output and no error.
- Counter
  - clk_cnt is wide enough for PULSE_WIDTH.
  - Loads N, then decrements to 0; the sample action happens on the cycle clk_cnt==0.
- State machine
  - IDLE: on rx_s==0, load clk_cnt=HALF_PULSE_WIDTH-1 and go to START.
  - START: at clk_cnt==0, resample rx_s.
    - If 1 (glitch): return to IDLE, no flag.
    - If 0: bit_cnt=0, clk_cnt=PULSE_WIDTH-1, go to DATA.
  - DATA: at clk_cnt==0, shift rx_s into shift_r at position bit_cnt (LSB first) and reload clk_cnt=PULSE_WIDTH-1.
    - After bit DATA_WIDTH-1: go to PAR if PARITY!=0, else STOP.
  - PAR: at clk_cnt==0, sample the parity bit, compute the mismatch flag, reload the counter, go to STOP.
    - Odd: XOR of data and parity bit must be 1.
    - Even: that XOR must be 0.
  - STOP: at clk_cnt==0, sample the stop bit.
    - If 1: deliver the word (see holding register), then go to IDLE.
    - If 0: frame_err=1 for one cycle, word discarded, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. This prevents a held-low line from producing repeated frames.
  - Unused encodings go to IDLE.
- Holding register
  - Delivery when valid==0, or valid==1 with ready==1 in the same cycle: data<=shift_r, valid<=1.
  - Delivery when valid==1 and ready==0: overrun=1 for one cycle. The new word is dropped and the old data is kept.
  - Parity error: parity_err pulses on the delivery cycle and the word is still delivered.
  - If parity_err and overrun coincide, both pulse.
  - valid & ready with no delivery that cycle: valid<=0.
  - valid is held while ready==0, with no timeout.
- Latency
  - Start-edge detect is 2 cycles after rx_sig falls (synchroniser).
  - valid rises 1 cycle after the stop-bit sample point.
  - The stop-bit sample sits about 9.5 bit times after the start edge, or 10.5 with parity.
- Back-to-back frames
  - A start bit may begin immediately after the stop-bit mid-point; IDLE detects it.
  - No minimum idle time is required.

Decomposition:
- Package uart_pkg:
  - rx state enum: IDLE, START, DATA, PAR, STOP, BREAK.
  - parity mode constants: PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - function pulse_width(clk_freq, baud).
- Sub-module uart_sync2: generic 2-flop synchroniser with a reset value parameter.
- The counter and the state machine stay in uart_rx.

Test Plan:
Bench parameters: CLK_FREQ=1_600_000, BAUD_RATE=100_000 (PULSE_WIDTH=16); bench drives rx_sig with 16-clk bits.
- Frame 0xA5, PARITY=0, ready=1 → one valid cycle with data=0xA5; no error pulses; valid rises 2+8+16*9+1 clocks after the falling edge (±1).
- 4-clk low glitch on the idle line → state returns to IDLE; valid, frame_err and overrun all stay 0.
- Frame 0x3C with stop bit=0, line held low for 40 bits → exactly one frame_err pulse, no valid; a following 0x55 frame is received correctly.
- PARITY=2: frame 0x07 with parity bit 1 → data=0x07, no error; same frame with parity bit 0 → data=0x07 delivered with parity_err pulse.
- ready=0, frames 0x11 then 0x22 → data stays 0x11, valid stays 1, one overrun pulse; raising ready for 1 cycle clears valid.
- rst asserted mid-DATA of 0xFF, released, then 0x81 sent → no output for the aborted frame; data=0x81 received correctly.
- Loopback through uart_tx at default parameters, 256 words back to back → all words match in order, zero error pulses.
